// File: rtl/p5_pkg.sv
// Shared constants and types for the write-back stage. The upstream stages
// reuse the same types for their forwarding compares.
package p5_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int ADDR_WIDTH  = 3;
    localparam int COUNT_WIDTH = 16;
    localparam int REG_COUNT   = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0]  word_t;
    typedef logic [ADDR_WIDTH-1:0]  reg_addr_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    localparam word_t     WORD_ZERO  = word_t'(0);
    localparam reg_addr_t ADDR_ZERO  = reg_addr_t'(0);
    localparam count_t    COUNT_ZERO = count_t'(0);
    localparam count_t    COUNT_ONE  = count_t'(1);

    // True when a read of readAddr must see the word being written this cycle.
    function automatic logic hitsWrite(input logic writeEn,
                                       input reg_addr_t writeAddr,
                                       input reg_addr_t readAddr);
        return writeEn && (writeAddr == readAddr);
    endfunction

endpackage

// File: rtl/p5_regarray.sv
// 8-entry general register file: one write port, two asynchronous read
// ports, asynchronous clear. Every entry is writable, r0 included.
module p5_regarray
    import p5_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  writeEn,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readAddrA,
    input  logic [ADDR_WIDTH-1:0] readAddrB,
    output logic [DATA_WIDTH-1:0] readDataA,
    output logic [DATA_WIDTH-1:0] readDataB
);

    word_t regs_r [REG_COUNT];

    // Register storage: cleared immediately on reset; the address is only
    // used when writeEn is high, so an unknown address on idle cycles is harmless.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= WORD_ZERO;
            end
        end else if (writeEn) begin
            regs_r[writeAddr] <= writeData;
        end
    end

    assign readDataA = regs_r[readAddrA];
    assign readDataB = regs_r[readAddrB];

endmodule

// File: rtl/p5_writeback_regfile.sv
// Write-back stage: owns the register file, gives decode write-first bypassed
// reads, gives execute a one-cycle-old forwarding bus, counts retired writes.
module p5_writeback_regfile
    import p5_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  wbData,
    input  logic                   wbWriteReg,
    input  logic [ADDR_WIDTH-1:0]  wbRegAddress,
    input  logic [ADDR_WIDTH-1:0]  readAddrA,
    input  logic [ADDR_WIDTH-1:0]  readAddrB,
    output logic [DATA_WIDTH-1:0]  readDataA,
    output logic [DATA_WIDTH-1:0]  readDataB,
    output logic                   fwdValid,
    output logic [ADDR_WIDTH-1:0]  fwdAddress,
    output logic [DATA_WIDTH-1:0]  fwdData,
    output logic [COUNT_WIDTH-1:0] retireCount
);

    word_t     arrDataA_s;
    word_t     arrDataB_s;
    word_t     readDataA_s;
    word_t     readDataB_s;
    logic      fwdValid_r;
    reg_addr_t fwdAddress_r;
    word_t     fwdData_r;
    count_t    retireCount_r;

    p5_regarray uRegArray (
        .clock     (clock),
        .reset     (reset),
        .writeEn   (wbWriteReg),
        .writeAddr (wbRegAddress),
        .writeData (wbData),
        .readAddrA (readAddrA),
        .readAddrB (readAddrB),
        .readDataA (arrDataA_s),
        .readDataB (arrDataB_s)
    );

    // Write-first bypass, applied to each read port independently.
    always_comb begin
        readDataA_s = arrDataA_s;
        readDataB_s = arrDataB_s;
        if (hitsWrite(wbWriteReg, wbRegAddress, readAddrA)) begin
            readDataA_s = wbData;
        end else begin
            readDataA_s = arrDataA_s;
        end
        if (hitsWrite(wbWriteReg, wbRegAddress, readAddrB)) begin
            readDataB_s = wbData;
        end else begin
            readDataB_s = arrDataB_s;
        end
    end

    // Forwarding bus: captures every cycle; consumers qualify with fwdValid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwdValid_r   <= 1'b0;
            fwdAddress_r <= ADDR_ZERO;
            fwdData_r    <= WORD_ZERO;
        end else begin
            fwdValid_r   <= wbWriteReg;
            fwdAddress_r <= wbRegAddress;
            fwdData_r    <= wbData;
        end
    end

    // Retired-write counter for debug; wraps silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retireCount_r <= COUNT_ZERO;
        end else if (wbWriteReg) begin
            retireCount_r <= retireCount_r + COUNT_ONE;
        end
    end

    assign readDataA   = readDataA_s;
    assign readDataB   = readDataB_s;
    assign fwdValid    = fwdValid_r;
    assign fwdAddress  = fwdAddress_r;
    assign fwdData     = fwdData_r;
    assign retireCount = retireCount_r;

endmodule

// File: tb/tb_p5_writeback_regfile.sv
// Directed self-checking bench for the write-back register file.
module tb_p5_writeback_regfile;

    logic        clock;
    logic        reset;
    logic [15:0] wbData;
    logic        wbWriteReg;
    logic [2:0]  wbRegAddress;
    logic [2:0]  readAddrA;
    logic [2:0]  readAddrB;
    logic [15:0] readDataA;
    logic [15:0] readDataB;
    logic        fwdValid;
    logic [2:0]  fwdAddress;
    logic [15:0] fwdData;
    logic [15:0] retireCount;

    int checkCount = 0;
    int passCount  = 0;

    p5_writeback_regfile dut (
        .clock        (clock),
        .reset        (reset),
        .wbData       (wbData),
        .wbWriteReg   (wbWriteReg),
        .wbRegAddress (wbRegAddress),
        .readAddrA    (readAddrA),
        .readAddrB    (readAddrB),
        .readDataA    (readDataA),
        .readDataB    (readDataB),
        .fwdValid     (fwdValid),
        .fwdAddress   (fwdAddress),
        .fwdData      (fwdData),
        .retireCount  (retireCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    // Advance past the next rising edge, then settle 1 time unit.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        wbData       = 16'h0000;
        wbWriteReg   = 1'b0;
        wbRegAddress = 3'd0;
        readAddrA    = 3'd0;
        readAddrB    = 3'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state of every register on both ports
        for (int a = 0; a < 8; a++) begin
            readAddrA = 3'(a);
            readAddrB = 3'(7 - a);
            #1;
            chk($sformatf("reset_rdA_r%0d", a), readDataA, 16'h0000);
            chk($sformatf("reset_rdB_r%0d", 7 - a), readDataB, 16'h0000);
        end
        chk("reset_fwdValid", {15'd0, fwdValid}, 16'h0000);
        chk("reset_fwdAddress", {13'd0, fwdAddress}, 16'h0000);
        chk("reset_fwdData", fwdData, 16'h0000);
        chk("reset_retireCount", retireCount, 16'h0000);

        // Write 0x1234 to r3, then read back with no write pending
        wbWriteReg = 1'b1; wbRegAddress = 3'd3; wbData = 16'h1234;
        tick();
        wbWriteReg = 1'b0; readAddrA = 3'd3; readAddrB = 3'd0;
        #1;
        chk("wr_rdA_r3", readDataA, 16'h1234);
        chk("wr_rdB_r0", readDataB, 16'h0000);
        chk("wr_fwdValid", {15'd0, fwdValid}, 16'h0001);
        chk("wr_fwdAddress", {13'd0, fwdAddress}, 16'h0003);
        chk("wr_fwdData", fwdData, 16'h1234);
        chk("wr_retire", retireCount, 16'h0001);
        tick();
        chk("wr_fwdValid_drop", {15'd0, fwdValid}, 16'h0000);
        chk("wr_retire_hold", retireCount, 16'h0001);

        // Bypass: r5 holds 0x00AA, then write 0xBEEF seen same cycle on both ports
        wbWriteReg = 1'b1; wbRegAddress = 3'd5; wbData = 16'h00AA;
        tick();
        wbData = 16'hBEEF; readAddrA = 3'd5; readAddrB = 3'd5;
        #1;
        chk("byp_rdA", readDataA, 16'hBEEF);
        chk("byp_rdB", readDataB, 16'hBEEF);
        readAddrB = 3'd3;
        #1;
        chk("byp_rdB_other", readDataB, 16'h1234);
        tick();
        wbWriteReg = 1'b0;
        #1;
        chk("byp_after_r5", readDataA, 16'hBEEF);
        chk("byp_retire", retireCount, 16'h0003);
        chk("byp_fwdData", fwdData, 16'hBEEF);

        // No-write: r2 = 0x5A5A, then 4 idle edges with r2 and 0xFFFF on the bus
        wbWriteReg = 1'b1; wbRegAddress = 3'd2; wbData = 16'h5A5A;
        tick();
        wbWriteReg = 1'b0; wbData = 16'hFFFF; readAddrA = 3'd2;
        #1;
        chk("nowr_no_bypass", readDataA, 16'h5A5A);
        for (int i = 0; i < 4; i++) tick();
        chk("nowr_r2", readDataA, 16'h5A5A);
        chk("nowr_retire", retireCount, 16'h0004);
        chk("nowr_fwdValid", {15'd0, fwdValid}, 16'h0000);
        chk("nowr_fwdData_captured", fwdData, 16'hFFFF);

        // Idle cycle with an unknown destination must not corrupt anything
        wbRegAddress = 3'bxxx;
        tick();
        wbRegAddress = 3'd0;
        readAddrA = 3'd3; readAddrB = 3'd5;
        #1;
        chk("xaddr_r3", readDataA, 16'h1234);
        chk("xaddr_r5", readDataB, 16'hBEEF);

        // Async reset between edges
        wbWriteReg = 1'b1; wbRegAddress = 3'd1; wbData = 16'h7777;
        tick();
        wbWriteReg = 1'b0; readAddrA = 3'd1;
        #1;
        chk("ar_r1_written", readDataA, 16'h7777);
        chk("ar_retire_pre", retireCount, 16'h0005);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_r1_cleared", readDataA, 16'h0000);
        chk("ar_fwdValid", {15'd0, fwdValid}, 16'h0000);
        chk("ar_retire", retireCount, 16'h0000);
        wbWriteReg = 1'b1; wbRegAddress = 3'd4; wbData = 16'h4444;
        tick();
        wbWriteReg = 1'b0;
        reset = 1'b0;
        readAddrA = 3'd4;
        #1;
        chk("ar_write_blocked", readDataA, 16'h0000);
        chk("ar_retire_blocked", retireCount, 16'h0000);
        chk("ar_fwd_blocked", {15'd0, fwdValid}, 16'h0000);

        // Counter wrap: 65535 writes reach 0xFFFF, the 65536th wraps to 0
        wbWriteReg = 1'b1; wbRegAddress = 3'd7;
        for (int i = 0; i < 65535; i++) begin
            wbData = 16'(i);
            tick();
        end
        chk("wrap_ffff", retireCount, 16'hFFFF);
        wbData = 16'hCAFE;
        tick();
        wbWriteReg = 1'b0; readAddrA = 3'd7;
        #1;
        chk("wrap_zero", retireCount, 16'h0000);
        chk("wrap_r7", readDataA, 16'hCAFE);
        chk("wrap_fwdValid", {15'd0, fwdValid}, 16'h0001);
        chk("wrap_fwdAddress", {13'd0, fwdAddress}, 16'h0007);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
